seq_pattern_detector: RTL and testbench
=======================================

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 Parameter PAT_W, default 3: pattern length in bits, legal range 2..16.
REQ-002 Parameter RESET_PAT, default 3'b101: pattern in force after reset, PAT_W bits.
REQ-003 Parameter MOORE, default 0: 0 selects Mealy output timing, 1 selects Moore output timing.
REQ-004 Parameter OVERLAP, default 1: 1 allows overlapping matches, 0 restarts the search after each match.
REQ-005 Parameter COUNT_W, default 8: width of the match counter.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 x  input  1  serial data bit, sampled only when x_valid=1.
REQ-009 x_valid  input  1  qualifies x; when x_valid=0 the bit is ignored and no state advances.
REQ-010 pat_load  input  1  one-cycle strobe that loads pat_in as the new pattern.
REQ-011 pat_in  input  PAT_W  new pattern; the first-received bit is the MSB.
REQ-012 cnt_clr  input  1  synchronous clear of match_count.
REQ-013 y  output  1  match indication; timing depends on MOORE.
REQ-014 match_count  output  COUNT_W  saturating count of matches.
REQ-015 busy  output  1  high while the history holds at least one valid bit (fill>0).

Function
REQ-016 The block SHALL keep a PAT_W-bit history shift register and a fill counter 0..PAT_W; each accepted bit shifts into the LSB and increments fill, saturating at PAT_W.
REQ-017 A match SHALL occur on an accepted bit when fill>=PAT_W-1 before the shift and {history[PAT_W-2:0], x} equals the pattern.
REQ-018 Mealy (MOORE=0): y SHALL be combinational and high in the same cycle as the completing bit with x_valid=1; y SHALL be low otherwise.
REQ-019 Moore (MOORE=1): y SHALL be registered and high for exactly the one cycle after the completing edge, regardless of x_valid in that cycle.
REQ-020 OVERLAP=1: after a match, history and fill SHALL be kept, so the next match may reuse bits.
REQ-021 OVERLAP=0: on a match, fill SHALL go to 0 on the same edge; no later match may use those bits.
REQ-022 The control FSM SHALL have states FILL (fill<PAT_W-1) and ARMED (next bit can complete a match); FILL->ARMED when fill reaches PAT_W-1; ARMED->FILL on pat_load, or on a match when OVERLAP=0.
REQ-023 match_count SHALL increment by 1 per match and hold at 2^COUNT_W-1 (no wrap).
REQ-024 cnt_clr together with a match on the same edge SHALL give match_count=0; clear wins.
REQ-025 pat_load SHALL, on the next edge, replace the pattern, set fill=0 and enter FILL; a bit accepted in the same cycle SHALL be discarded and SHALL produce no match, including no Mealy y.
REQ-026 pat_load SHALL NOT alter match_count.

Reset
REQ-027 While reset_n=0, pattern=RESET_PAT, history=0, fill=0, FSM=FILL, Moore y register=0, match_count=0, and busy=0; Mealy y=0 follows from fill=0.
REQ-028 A reset asserted mid-sequence SHALL discard all partial history; no match may span a reset.

Structure
REQ-029 Package seq_det_pkg SHALL hold the FSM state enum and the PAT_W range constants.
REQ-030 The saturating counter SHALL be a sub-module sat_counter (parameter WIDTH; ports inc, clr, count).

Verification (PAT_W=3, pattern 101 unless stated)
REQ-031 Accepted stream 1,0,0,1,0,1,0,1,1,0,1 with OVERLAP=1 -> match on bits 6, 8 and 11; match_count=3.
REQ-032 Same stream with OVERLAP=0 -> match on bits 6 and 11 only; match_count=2.
REQ-033 MOORE=0 against MOORE=1 on the stream 1,0,1 -> Mealy y high during the cycle of bit 3; Moore y high for the cycle after the bit-3 edge.
REQ-034 Apply pat_load with pat_in=3'b110, then stream 1,1,0,1,1,0 -> matches on bits 3 and 6; pat_load asserted with x_valid=1 -> no y and no count change.
REQ-035 COUNT_W=2 with 5 matches -> match_count stays at 3; cnt_clr on the cycle of a match -> match_count=0.
REQ-036 Pulse reset_n low after bits 1,0, then send 1 -> no match; busy=0 during reset.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_det_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } det_state_e;

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones; a synchronous clear takes priority over inc.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with loadable pattern, Mealy/Moore output timing,
// optional overlapping matches and a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int             PAT_W     = 3,
  parameter logic [PAT_W-1:0] RESET_PAT = 3'b101,
  parameter bit             MOORE     = 1'b0,
  parameter bit             OVERLAP   = 1'b1,
  parameter int             COUNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               x,
  input  logic               x_valid,
  input  logic               pat_load,
  input  logic [PAT_W-1:0]   pat_in,
  input  logic               cnt_clr,
  output logic               y,
  output logic [COUNT_W-1:0] match_count,
  output logic               busy
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_PRE  = FILL_W'(PAT_W - 2);

  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_pattern_detector: PAT_W out of range");
  end

  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  hist_q;
  logic [FILL_W-1:0] fill_q;
  det_state_e        state_q;
  logic              y_q;

  logic              accept;
  logic [PAT_W-1:0]  cand;
  logic              match;

  // A bit arriving alongside pat_load belongs to the old pattern and is dropped.
  assign accept = x_valid && !pat_load;
  assign cand   = {hist_q[PAT_W-2:0], x};
  assign match  = accept && (state_q == ST_ARMED) && (cand == pat_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q   <= RESET_PAT;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= ST_FILL;
      y_q     <= 1'b0;
    end else begin
      y_q <= match;
      if (pat_load) begin
        pat_q   <= pat_in;
        fill_q  <= '0;
        state_q <= ST_FILL;
      end else if (x_valid) begin
        hist_q <= cand;
        if (match && !OVERLAP) begin
          fill_q  <= '0;
          state_q <= ST_FILL;
        end else begin
          if (fill_q != FILL_FULL) begin
            fill_q <= fill_q + 1'b1;
          end
          // Armed once PAT_W-1 bits are held, so the next bit can complete a match.
          if (fill_q >= FILL_PRE) begin
            state_q <= ST_ARMED;
          end
        end
      end
    end
  end

  sat_counter #(
    .WIDTH (COUNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (match),
    .clr   (cnt_clr),
    .count (match_count)
  );

  assign y    = MOORE ? y_q : match;
  assign busy = (fill_q != '0);

endmodule : seq_pattern_detector

// File: tb/tb_seq_pattern_detector.sv
// Directed bench driving four detector configurations in lockstep against a scoreboard.
module tb_seq_pattern_detector;

  localparam int PW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          x = 1'b0, x_valid = 1'b0, pat_load = 1'b0, cnt_clr = 1'b0;
  logic [PW-1:0] pat_in = '0;

  logic       y0, y1, y2, y3;
  logic       b0, b1, b2, b3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;

  // 0: Mealy overlap, 1: Mealy non-overlap, 2: Moore overlap, 3: Mealy overlap 2-bit count
  seq_pattern_detector #(.PAT_W(PW), .RESET_PAT(3'b101), .MOORE(1'b0), .OVERLAP(1'b1), .COUNT_W(8)) u0 (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y0), .match_count(c0), .busy(b0));
  seq_pattern_detector #(.PAT_W(PW), .RESET_PAT(3'b101), .MOORE(1'b0), .OVERLAP(1'b0), .COUNT_W(8)) u1 (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y1), .match_count(c1), .busy(b1));
  seq_pattern_detector #(.PAT_W(PW), .RESET_PAT(3'b101), .MOORE(1'b1), .OVERLAP(1'b1), .COUNT_W(8)) u2 (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y2), .match_count(c2), .busy(b2));
  seq_pattern_detector #(.PAT_W(PW), .RESET_PAT(3'b101), .MOORE(1'b0), .OVERLAP(1'b1), .COUNT_W(2)) u3 (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y3), .match_count(c3), .busy(b3));

  typedef struct {
    string       tag;
    int          inst;
    int          kind;
    logic [31:0] expv;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference state: accepted bits since the last restart, kept as an unbounded length.
  logic [15:0]   hist_m[4];
  int            len_m[4];
  int            cnt_m[4];
  logic [PW-1:0] pat_m[4];
  bit            ovl_m[4];
  int            cmax_m[4];
  bit            moore_pend;

  function automatic logic [31:0] obs(input int inst, input int kind);
    logic [31:0] r;
    r = 'x;
    case ({inst[1:0], kind[1:0]})
      4'b00_00: r = {31'd0, y0};
      4'b01_00: r = {31'd0, y1};
      4'b10_00: r = {31'd0, y2};
      4'b11_00: r = {31'd0, y3};
      4'b00_01: r = {24'd0, c0};
      4'b01_01: r = {24'd0, c1};
      4'b10_01: r = {24'd0, c2};
      4'b11_01: r = {30'd0, c3};
      4'b00_10: r = {31'd0, b0};
      4'b01_10: r = {31'd0, b1};
      4'b10_10: r = {31'd0, b2};
      4'b11_10: r = {31'd0, b3};
      default:  r = 'x;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, o, e);
    end
  endtask

  task automatic drain();
    exp_t t;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      check(t.tag, obs(t.inst, t.kind), t.expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hist_m[i] = '0;
      len_m[i]  = 0;
      cnt_m[i]  = 0;
      pat_m[i]  = 3'b101;
    end
    moore_pend = 1'b0;
  endtask

  task automatic push_state();
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{tag: $sformatf("cnt%0d", i), inst: i, kind: 1, expv: cnt_m[i]});
      sb.push_back('{tag: $sformatf("busy%0d", i), inst: i, kind: 2, expv: {31'd0, (len_m[i] > 0)}});
    end
  endtask

  task automatic do_reset();
    x_valid  = 1'b0;
    x        = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    reset_n  = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{tag: $sformatf("rst_y%0d", i), inst: i, kind: 0, expv: 0});
    end
    push_state();
    drain();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{tag: $sformatf("rst_busy%0d", i), inst: i, kind: 2, expv: 0});
    end
    drain();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit xv, input bit xb, input bit pl = 1'b0,
                      input logic [PW-1:0] pin = '0, input bit clr = 1'b0);
    bit m[4];
    x_valid  = xv;
    x        = xb;
    pat_load = pl;
    pat_in   = pin;
    cnt_clr  = clr;
    for (int i = 0; i < 4; i++) begin
      m[i] = xv && !pl && (len_m[i] >= PW - 1) && ({hist_m[i][1:0], xb} == pat_m[i]);
    end
    sb.push_back('{tag: "y0_mealy", inst: 0, kind: 0, expv: {31'd0, m[0]}});
    sb.push_back('{tag: "y1_mealy", inst: 1, kind: 0, expv: {31'd0, m[1]}});
    sb.push_back('{tag: "y2_moore", inst: 2, kind: 0, expv: {31'd0, moore_pend}});
    sb.push_back('{tag: "y3_mealy", inst: 3, kind: 0, expv: {31'd0, m[3]}});
    @(negedge clk);
    drain();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (pl) begin
        len_m[i] = 0;
        pat_m[i] = pin;
      end else if (xv) begin
        if (m[i] && !ovl_m[i]) begin
          len_m[i] = 0;
        end else begin
          hist_m[i] = {hist_m[i][14:0], xb};
          len_m[i]++;
        end
      end
      if (clr) cnt_m[i] = 0;
      else if (m[i] && cnt_m[i] < cmax_m[i]) cnt_m[i]++;
    end
    moore_pend = m[2];
    #1;
    push_state();
    drain();
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit s1[11];
    bit s2[6];
    s1 = '{1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1};
    s2 = '{1, 1, 0, 1, 1, 0};
    ovl_m  = '{1'b1, 1'b0, 1'b1, 1'b1};
    cmax_m = '{255, 255, 255, 3};

    do_reset();

    // Reference stream with idle (ignored) cycles interleaved.
    foreach (s1[i]) begin
      step(1'b1, s1[i]);
      if (i == 4) step(1'b0, 1'b1);
    end
    step(1'b0, 1'b1);
    check("stream_cnt_overlap", {24'd0, c0}, 3);
    check("stream_cnt_nooverlap", {24'd0, c1}, 2);
    check("stream_cnt_moore", {24'd0, c2}, 3);

    // Mealy/Moore timing on 1,0,1, then pattern reload colliding with a would-be match.
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'b110);
    check("load_keeps_cnt", {24'd0, c0}, 1);
    foreach (s2[i]) step(1'b1, s2[i]);
    check("pat110_cnt_overlap", {24'd0, c0}, 3);
    check("pat110_cnt_nooverlap", {24'd0, c1}, 3);

    // Saturation of the 2-bit counter, then clear racing a match.
    foreach (s2[i]) step(1'b1, s2[i]);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("sat_cnt_wide", {24'd0, c0}, 6);
    check("sat_cnt_narrow", {30'd0, c3}, 3);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("clr_wins_wide", {24'd0, c0}, 0);
    check("clr_wins_narrow", {30'd0, c3}, 0);

    // Reset between 1,0 and 1 must not let a match span it.
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b1);
    check("post_reset_cnt", {24'd0, c0}, 0);
    step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_pattern_detector
